// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: word width, memory depth,
// port indices and the request payload carried from a port to the memory.
package dmem_arbiter_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned DMEM_SIZE = 1024;

  // Port indices into the 2-bit request/grant vectors.
  localparam int unsigned P_CPU = 0;
  localparam int unsigned P_LDR = 1;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  // True when addr names a real memory word (0..size-1).
  function automatic logic in_range(input logic [WORD_W-1:0] addr,
                                    input int unsigned       size);
    return addr < WORD_W'(size);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick. Holds last_grant (0 = port 0, 1 = port 1) and,
// on a tie, grants the port that was not granted most recently.
// Ports:
//   clk, reset  - clock, async active-high reset (last_grant resets to 1)
//   req[1:0]    - requests, bit index = port
//   gnt[1:0]    - one-hot grant, combinational from req and last_grant
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant;

  // Port 0 wins when alone or when port 1 was served last.
  always_comb begin
    gnt = 2'b00;
    if (req[P_CPU] && (!req[P_LDR] || last_grant)) begin
      gnt[P_CPU] = 1'b1;
    end else if (req[P_LDR]) begin
      gnt[P_LDR] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (|gnt) begin
      last_grant <= gnt[P_LDR];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data_memory between the pipeline memory stage (port 0) and the
// program/debug loader (port 1). One access is granted per cycle; the granted
// request drives the memory strobes, address and write data. Read responses
// (and out-of-range errors) return to the owning port one cycle after grant.
// Ports:
//   clk, reset                      - clock, async active-high reset
//   pN_req/we/addr/wdata            - port N request (held until pN_gnt)
//   pN_gnt                          - port N accepted this cycle (combinational)
//   pN_rvalid/rdata/err             - port N response, one cycle after grant
//   mem_read/write/address/write_data, mem_read_data - data_memory interface
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned SIZE = DMEM_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [WORD_W-1:0] p0_addr,
  input  logic [WORD_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [WORD_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [WORD_W-1:0] p1_addr,
  input  logic [WORD_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [WORD_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_write_data,
  input  logic [WORD_W-1:0] mem_read_data
);

  logic [1:0] req;
  logic [1:0] gnt;
  mem_req_t   p0_bus;
  mem_req_t   p1_bus;
  mem_req_t   sel;
  logic       any_gnt;
  logic       sel_ok;

  // Response registers: who owns the next-cycle response and what kind it is.
  logic       resp_port;
  logic       resp_valid;
  logic       resp_err;

  // Requests are masked during reset so no grant can be issued.
  assign req = {p1_req, p0_req} & {2{~reset}};

  rr_arbiter2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign p0_gnt = gnt[P_CPU];
  assign p1_gnt = gnt[P_LDR];

  assign p0_bus = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
  assign p1_bus = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};

  // Granted-request mux; zero payload when nothing is granted.
  always_comb begin
    sel = '0;
    if (gnt[P_CPU]) begin
      sel = p0_bus;
    end else if (gnt[P_LDR]) begin
      sel = p1_bus;
    end
  end

  assign any_gnt = |gnt;
  assign sel_ok  = in_range(sel.addr, SIZE);

  // Out-of-range accesses are granted but never reach the memory.
  assign mem_address    = sel.addr;
  assign mem_write_data = sel.wdata;
  assign mem_write      = any_gnt & sel_ok & sel.we;
  assign mem_read       = any_gnt & sel_ok & ~sel.we;

  // Reset clears any in-flight response so it is never delivered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_port  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      resp_port  <= gnt[P_LDR];
      resp_valid <= any_gnt & ~sel.we;
      resp_err   <= any_gnt & ~sel_ok;
    end
  end

  // Memory read data is passed through only for an in-range read response.
  assign p0_rvalid = resp_valid & ~resp_port;
  assign p1_rvalid = resp_valid & resp_port;
  assign p0_err    = resp_err & ~resp_port;
  assign p1_err    = resp_err & resp_port;
  assign p0_rdata  = (p0_rvalid && !resp_err) ? mem_read_data : '0;
  assign p1_rdata  = (p1_rvalid && !resp_err) ? mem_read_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven check of dmem_arbiter against a behavioural data_memory model,
// plus a hand-written reset sequence.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        p0r; logic p0w; logic [31:0] p0a; logic [31:0] p0d;
    logic        p1r; logic p1w; logic [31:0] p1a; logic [31:0] p1d;
    logic [1:0]  eg;   // {p1_gnt, p0_gnt}
    logic        emrd;
    logic        emwr;
    logic [31:0] ema;
    logic [31:0] emd;
    logic [1:0]  erv;  // {p1_rvalid, p0_rvalid}
    logic [1:0]  eer;  // {p1_err, p0_err}
    logic [31:0] ed0;
    logic [31:0] ed1;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  dmem_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .p0_req         (p0_req),
    .p0_we          (p0_we),
    .p0_addr        (p0_addr),
    .p0_wdata       (p0_wdata),
    .p0_gnt         (p0_gnt),
    .p0_rvalid      (p0_rvalid),
    .p0_rdata       (p0_rdata),
    .p0_err         (p0_err),
    .p1_req         (p1_req),
    .p1_we          (p1_we),
    .p1_addr        (p1_addr),
    .p1_wdata       (p1_wdata),
    .p1_gnt         (p1_gnt),
    .p1_rvalid      (p1_rvalid),
    .p1_rdata       (p1_rdata),
    .p1_err         (p1_err),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read data memory model.
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[9:0]] <= mem_write_data;
    if (mem_read)  mem_read_data <= mem[mem_address[9:0]];
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic a_r, input logic a_w, input logic [31:0] a_a, input logic [31:0] a_d,
                       input logic b_r, input logic b_w, input logic [31:0] b_a, input logic [31:0] b_d);
    p0_req = a_r; p0_we = a_w; p0_addr = a_a; p0_wdata = a_d;
    p1_req = b_r; p1_we = b_w; p1_addr = b_a; p1_wdata = b_d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".gnt"},  {30'd0, p1_gnt, p0_gnt}, 32'd0);
    chk({tag, ".strb"}, {30'd0, mem_write, mem_read}, 32'd0);
    chk({tag, ".ma"},   mem_address, 32'd0);
    chk({tag, ".md"},   mem_write_data, 32'd0);
    chk({tag, ".rv"},   {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    chk({tag, ".err"},  {30'd0, p1_err, p0_err}, 32'd0);
    chk({tag, ".rd0"},  p0_rdata, 32'd0);
    chk({tag, ".rd1"},  p1_rdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + 32'(i);
    mem_read_data = 32'd0;

    //          p0: req we addr wdata          p1: req we addr wdata           gnt  rd wr addr  wdata     rv    er    rd0          rd1
    vecs[0]  = '{1, 1, 32'd5,    32'hDEAD, 0, 0, 32'd0,    32'h0,    2'b01, 0, 1, 32'd5,    32'hDEAD, 2'b00, 2'b00, 32'h0,    32'h0};
    vecs[1]  = '{1, 0, 32'd5,    32'h0,    0, 0, 32'd0,    32'h0,    2'b01, 1, 0, 32'd5,    32'h0,    2'b00, 2'b00, 32'h0,    32'h0};
    vecs[2]  = '{0, 0, 32'd0,    32'h0,    0, 0, 32'd0,    32'h0,    2'b00, 0, 0, 32'd0,    32'h0,    2'b01, 2'b00, 32'hDEAD, 32'h0};
    vecs[3]  = '{1, 0, 32'd10,   32'hA0,   1, 0, 32'd20,   32'hB0,   2'b10, 1, 0, 32'd20,   32'hB0,   2'b00, 2'b00, 32'h0,    32'h0};
    vecs[4]  = '{1, 0, 32'd10,   32'hA0,   1, 0, 32'd20,   32'hB0,   2'b01, 1, 0, 32'd10,   32'hA0,   2'b10, 2'b00, 32'h0,    32'h1014};
    vecs[5]  = '{1, 0, 32'd10,   32'hA0,   1, 0, 32'd20,   32'hB0,   2'b10, 1, 0, 32'd20,   32'hB0,   2'b01, 2'b00, 32'h100A, 32'h0};
    vecs[6]  = '{1, 0, 32'd10,   32'hA0,   1, 0, 32'd20,   32'hB0,   2'b01, 1, 0, 32'd10,   32'hA0,   2'b10, 2'b00, 32'h0,    32'h1014};
    vecs[7]  = '{1, 0, 32'd10,   32'hA0,   1, 0, 32'd20,   32'hB0,   2'b10, 1, 0, 32'd20,   32'hB0,   2'b01, 2'b00, 32'h100A, 32'h0};
    vecs[8]  = '{1, 0, 32'd10,   32'hA0,   1, 0, 32'd20,   32'hB0,   2'b01, 1, 0, 32'd10,   32'hA0,   2'b10, 2'b00, 32'h0,    32'h1014};
    vecs[9]  = '{0, 0, 32'd0,    32'h0,    1, 1, 32'd9,    32'h1234, 2'b10, 0, 1, 32'd9,    32'h1234, 2'b01, 2'b00, 32'h100A, 32'h0};
    vecs[10] = '{1, 0, 32'd9,    32'h0,    0, 0, 32'd0,    32'h0,    2'b01, 1, 0, 32'd9,    32'h0,    2'b00, 2'b00, 32'h0,    32'h0};
    vecs[11] = '{0, 0, 32'd0,    32'h0,    0, 0, 32'd0,    32'h0,    2'b00, 0, 0, 32'd0,    32'h0,    2'b01, 2'b00, 32'h1234, 32'h0};
    vecs[12] = '{1, 0, 32'd1024, 32'h0,    0, 0, 32'd0,    32'h0,    2'b01, 0, 0, 32'd1024, 32'h0,    2'b00, 2'b00, 32'h0,    32'h0};
    vecs[13] = '{1, 1, 32'd2000, 32'h55,   0, 0, 32'd0,    32'h0,    2'b01, 0, 0, 32'd2000, 32'h55,   2'b01, 2'b01, 32'h0,    32'h0};
    vecs[14] = '{0, 0, 32'd0,    32'h0,    1, 0, 32'd4000, 32'h0,    2'b10, 0, 0, 32'd4000, 32'h0,    2'b00, 2'b01, 32'h0,    32'h0};
    vecs[15] = '{0, 0, 32'd0,    32'h0,    1, 0, 32'd1023, 32'h0,    2'b10, 1, 0, 32'd1023, 32'h0,    2'b10, 2'b10, 32'h0,    32'h0};
    vecs[16] = '{0, 0, 32'd0,    32'h0,    0, 0, 32'd0,    32'h0,    2'b00, 0, 0, 32'd0,    32'h0,    2'b10, 2'b00, 32'h0,    32'h13FF};

    // Reset with both ports requesting: everything must stay quiet.
    reset = 1'b1;
    drive(1, 0, 32'd7, 32'h0, 1, 0, 32'd7, 32'h0);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 32'd0, 32'h0, 0, 0, 32'd0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].p0r, vecs[i].p0w, vecs[i].p0a, vecs[i].p0d,
            vecs[i].p1r, vecs[i].p1w, vecs[i].p1a, vecs[i].p1d);
      #1;
      chk($sformatf("v%0d.gnt", i),  {30'd0, p1_gnt, p0_gnt}, {30'd0, vecs[i].eg});
      chk($sformatf("v%0d.mrd", i),  {31'd0, mem_read},  {31'd0, vecs[i].emrd});
      chk($sformatf("v%0d.mwr", i),  {31'd0, mem_write}, {31'd0, vecs[i].emwr});
      chk($sformatf("v%0d.ma", i),   mem_address,    vecs[i].ema);
      chk($sformatf("v%0d.md", i),   mem_write_data, vecs[i].emd);
      chk($sformatf("v%0d.rv", i),   {30'd0, p1_rvalid, p0_rvalid}, {30'd0, vecs[i].erv});
      chk($sformatf("v%0d.err", i),  {30'd0, p1_err, p0_err}, {30'd0, vecs[i].eer});
      chk($sformatf("v%0d.rd0", i),  p0_rdata, vecs[i].ed0);
      chk($sformatf("v%0d.rd1", i),  p1_rdata, vecs[i].ed1);
    end

    // Port 1 read granted, then reset pulsed before the capturing edge.
    @(negedge clk);
    drive(0, 0, 32'd0, 32'h0, 1, 0, 32'd3, 32'h0);
    #1;
    chk("rst_flight.gnt1", {31'd0, p1_gnt}, 32'd1);
    chk("rst_flight.mrd",  {31'd0, mem_read}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("rst_pulse");
    // Deassert with a tie pending: port 0 must win, dropped response stays dropped.
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 32'd4, 32'h0, 1, 0, 32'd3, 32'h0);
    #1;
    chk("post_rst.gnt",  {30'd0, p1_gnt, p0_gnt}, 32'd1);
    chk("post_rst.rv1",  {31'd0, p1_rvalid}, 32'd0);
    chk("post_rst.ma",   mem_address, 32'd4);
    @(negedge clk);
    drive(0, 0, 32'd0, 32'h0, 0, 0, 32'd0, 32'h0);
    #1;
    chk("post_rst.rv",   {30'd0, p1_rvalid, p0_rvalid}, 32'd1);
    chk("post_rst.rd0",  p0_rdata, 32'h1004);
    chk("post_rst.rd1",  p1_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
